// File: rtl/ifetch.sv
// Instruction fetch stage: single-outstanding req/gnt reads from instruction memory into a small FIFO feeding decode.
// Build option MYCPU_IFETCH_SKID_EN: two-entry buffer so the next fetch overlaps a word waiting on decode.
module ifetch #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc_in,
    input  logic          fetch_en,
    input  logic          flush,
    output logic          pc_adv,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [DW-1:0] instr_out,
    output logic [AW-1:0] instr_pc
);

`ifdef MYCPU_IFETCH_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state, state_nx;
    logic          discard;
    logic          push, pop, load_addr, set_discard, clr_discard, can_start;
    logic [CW-1:0] count;
    logic [CW:0]   occ;
    logic [PW-1:0] wptr, rptr;
    logic [DW-1:0] buf_data [DEPTH];
    logic [AW-1:0] buf_pc   [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Space is reserved at request time: words held plus the one in flight.
    assign occ       = {1'b0, count} + {{CW{1'b0}}, (state == WAIT)};
    assign can_start = fetch_en && !flush && (occ < (CW + 1)'(DEPTH));

    assign instr_valid = (count != '0);
    assign instr_out   = buf_data[rptr];
    assign instr_pc    = buf_pc[rptr];
    assign pop         = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            imem_addr <= '0;
            discard   <= 1'b0;
        end else begin
            state <= state_nx;
            if (load_addr)
                imem_addr <= pc_in;
            if (set_discard)
                discard <= 1'b1;
            else if (clr_discard)
                discard <= 1'b0;
        end
    end

    always_comb begin
        state_nx    = state;
        imem_req    = 1'b0;
        pc_adv      = 1'b0;
        push        = 1'b0;
        load_addr   = 1'b0;
        set_discard = 1'b0;
        clr_discard = 1'b0;
        unique case (state)
            IDLE: begin
                if (can_start) begin
                    state_nx  = REQ;
                    load_addr = 1'b1;
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    pc_adv = 1'b1;
                    // Zero-latency response completes here; pc_in is not yet advanced, so return via IDLE.
                    if (imem_rvalid) begin
                        push     = !flush;
                        state_nx = IDLE;
                    end else begin
                        set_discard = flush;
                        state_nx    = WAIT;
                    end
                end else if (flush) begin
                    state_nx = IDLE;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push        = !discard && !flush;
                    clr_discard = 1'b1;
                    if (can_start) begin
                        state_nx  = REQ;
                        load_addr = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (flush) begin
                    set_discard = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (flush) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            if (push) begin
                buf_data[wptr] <= imem_rdata;
                buf_pc[wptr]   <= imem_addr;
                wptr           <= ptr_inc(wptr);
            end
            if (pop)
                rptr <= ptr_inc(rptr);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule
